// File: rtl/pipe_ctrl_chain.sv
// Control-word pipeline: STAGES registers with per-stage stall/flush, a stall
// back-pressure chain, an occupancy count and a wrapping retire counter.
module pipe_ctrl_chain #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 3,
    parameter int CW     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              in_ctrl,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [STAGES-1:0]             stall,
    input  logic [STAGES-1:0]             flush,
    output logic [STAGES*WIDTH-1:0]       out_ctrl,
    output logic [STAGES-1:0]             out_valid,
    output logic [$clog2(STAGES+1)-1:0]   occupancy,
    output logic [CW-1:0]                 retire_cnt
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [WIDTH-1:0]  ctrl_q [STAGES];
    logic [WIDTH-1:0]  ctrl_d [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [CW-1:0]     ret_q;
    logic [CW-1:0]     ret_d;
    logic [STAGES-1:0] hold;

    // A stall anywhere downstream freezes every stage upstream of it.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc | stall[k];
            hold[k] = acc;
        end
    end

    assign in_ready = ~hold[0];

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ctrl_d[k] = ctrl_q[k];
        end
        vld_d = vld_q;
        ret_d = ret_q;

        if (flush[0]) begin
            ctrl_d[0] = '0;
            vld_d[0]  = 1'b0;
        end else if (!hold[0]) begin
            ctrl_d[0] = in_valid ? in_ctrl : '0;
            vld_d[0]  = in_valid;
        end

        // A held upstream stage leaves a bubble behind in the stage that advances.
        for (int k = 1; k < STAGES; k++) begin
            if (flush[k]) begin
                ctrl_d[k] = '0;
                vld_d[k]  = 1'b0;
            end else if (!hold[k]) begin
                if (stall[k-1]) begin
                    ctrl_d[k] = '0;
                    vld_d[k]  = 1'b0;
                end else begin
                    ctrl_d[k] = ctrl_q[k-1];
                    vld_d[k]  = vld_q[k-1];
                end
            end
        end

        if (vld_q[STAGES-1] && !stall[STAGES-1] && !flush[STAGES-1]) begin
            ret_d = ret_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
            end
            vld_q <= '0;
            ret_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
            vld_q <= vld_d;
            ret_q <= ret_d;
        end
    end

    always_comb begin
        out_ctrl  = '0;
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            out_ctrl[k*WIDTH +: WIDTH] = ctrl_q[k];
            occupancy = occupancy + OCC_W'(vld_q[k]);
        end
    end

    assign out_valid  = vld_q;
    assign retire_cnt = ret_q;

endmodule

// File: doc/pipe_ctrl_chain.md
PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

Interface
REQ-001 SHALL provide parameter WIDTH, default 10, bit width of one control word.
REQ-002 SHALL provide parameter STAGES, default 3, number of pipeline register stages (stage 0 = first after decode, stage STAGES-1 = last).
REQ-003 SHALL provide parameter CW, default 16, width of the retire counter.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_ctrl  input  WIDTH  control word offered to stage 0.
REQ-007 SHALL have port in_valid  input  1  in_ctrl carries a real instruction.
REQ-008 SHALL have port in_ready  output  1  stage 0 accepts in_ctrl this cycle.
REQ-009 SHALL have port stall  input  STAGES  bit k requests stage k hold its contents.
REQ-010 SHALL have port flush  input  STAGES  bit k requests stage k become a bubble.
REQ-011 SHALL have port out_ctrl  output  STAGES*WIDTH  stage k word at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port out_valid  output  STAGES  bit k = stage k holds a real instruction.
REQ-013 SHALL have port occupancy  output  clog2(STAGES+1)  count of set out_valid bits.
REQ-014 SHALL have port retire_cnt  output  CW  number of instructions retired from the last stage.

Function
REQ-015 SHALL compute hold h[k] = stall[k] OR h[k+1], with h[STAGES-1] = stall[STAGES-1] (a stall propagates to all upstream stages, combinationally, same cycle).
REQ-016 SHALL drive in_ready = NOT h[0]; in_ctrl/in_valid SHALL be ignored when in_ready = 0 (producer holds them).
REQ-017 SHALL, at each clock edge, update stage k with priority flush > hold > advance.
REQ-018 SHALL, when flush[k] = 1, load stage k with ctrl = 0 and valid = 0, regardless of h[k].
REQ-019 SHALL, when flush[k] = 0 and h[k] = 1, keep stage k ctrl and valid unchanged.
REQ-020 SHALL, when stage 0 advances, load in_ctrl and in_valid (ctrl forced to 0 when in_valid = 0).
REQ-021 SHALL, when stage k>0 advances and stall[k-1] = 1, load a bubble (ctrl 0, valid 0); otherwise load stage k-1 ctrl and valid.
REQ-022 SHALL store ctrl = 0 in every invalid stage, so out_ctrl of a bubble is all zeros.
REQ-023 SHALL give one-cycle latency per stage: an accepted word appears on stage k out_ctrl k+1 edges after acceptance absent stall/flush.
REQ-024 SHALL increment retire_cnt by 1 on each edge where out_valid[STAGES-1] = 1, stall[STAGES-1] = 0 and flush[STAGES-1] = 0; wraps from 2^CW-1 to 0.
REQ-025 SHALL derive occupancy combinationally from the registered valid bits.
REQ-026 SHALL treat a stage that is flushed while downstream stalls as a bubble held in place on subsequent hold cycles.
REQ-027 SHALL support STAGES = 1 (no inter-stage bubble path) and any WIDTH >= 1.

Reset
REQ-028 SHALL, while reset = 0, asynchronously clear every stage ctrl and valid to 0 and retire_cnt to 0; in_ready then equals NOT stall[0]|...|stall[STAGES-1].
REQ-029 SHALL, on reset deassertion, resume normal operation at the first rising edge with all stages as bubbles; reset asserted mid-operation SHALL discard all in-flight words.

Verification (STAGES=3, WIDTH=10, CW=16)
REQ-030 SHALL cover: reset low, then in_valid=1 in_ctrl=0x155 one cycle, no stall -> out_ctrl stage 0/1/2 = 0x155 on edges 1/2/3, out_valid walks 001->010->100->000, retire_cnt = 1.
REQ-031 SHALL cover: three words 0x001,0x002,0x003 back to back, stall[1]=1 for 2 cycles -> in_ready=0 those cycles, stages 0,1 hold, stage 2 receives bubbles (valid 0, ctrl 0), no word lost, retire_cnt ends 3.
REQ-032 SHALL cover: pipeline full, flush=3'b011 with stall[2]=1 same cycle -> stages 0,1 bubble, stage 2 held, occupancy 3->1, retire_cnt unchanged.
REQ-033 SHALL cover: retire_cnt preset to 0xFFFF via 65535 retirements, one more retirement -> retire_cnt = 0x0000.
REQ-034 SHALL cover: reset pulled low asynchronously between edges with occupancy 3 -> out_valid = 000, out_ctrl = 0, retire_cnt = 0 immediately, without a clock edge.
